// File: rtl/sd_clk_gen.sv
// SDCLK generator: D1/D2 pairs for a SAME_EDGE ODDR, edge strobes and a stable flag; all outputs registered, one-cycle latency.
// No backpressure. Optional SDCLK_PAUSE_EN adds pause_i to park SDCLK low after the current high phase.
module sd_clk_gen #(
    parameter int                DIV_W      = 10,
    parameter logic [DIV_W-1:0]  DIV_RESET  = DIV_W'(128),
    parameter int                STABLE_CYC = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clk_en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
`ifdef SDCLK_PAUSE_EN
    input  logic             pause_i,
`endif
    output logic             oddr_d1_o,
    output logic             oddr_d2_o,
    output logic             oddr_ce_o,
    output logic             sd_rise_o,
    output logic             sd_fall_o,
    output logic             clk_stable_o
);

    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);

    typedef enum logic [2:0] {S_OFF, S_RUN, S_STOP, S_RELOAD, S_PAUSE} state_t;

    state_t           r_state, w_nx_state, w_exit_st;
    logic [DIV_W-1:0] r_cnt, w_nx_cnt, r_div_q, w_nx_div_q, r_div_pend;
    logic             r_level, w_nx_level, r_reload_req;
    logic             w_last, w_stop, w_start, w_pause;
    logic             w_run_nx, w_div0_nx, w_nx_d1, w_nx_d2;
    logic             r_d1, r_d2, r_ce, r_rise, r_fall, r_stable;
    logic [SW-1:0]    r_stab, w_stab_inc;

`ifdef SDCLK_PAUSE_EN
    assign w_pause = pause_i;
`else
    assign w_pause = 1'b0;
`endif

    assign w_last     = (r_cnt == r_div_q - DIV_W'(1));
    assign w_stop     = !clk_en_i || div_load_i || w_pause;
    assign w_stab_inc = (r_stab == STAB_MAX) ? r_stab : r_stab + SW'(1);

    // Where SDCLK goes once it is (or already was) parked low.
    always_comb begin
        w_exit_st = S_RELOAD;
        if (!clk_en_i)
            w_exit_st = S_OFF;
        else if (r_reload_req || div_load_i)
            w_exit_st = S_RELOAD;
        else if (w_pause)
            w_exit_st = S_PAUSE;
    end

    always_comb begin
        w_nx_state = r_state;
        w_nx_cnt   = r_cnt;
        w_nx_level = r_level;
        w_nx_div_q = r_div_q;
        w_start    = 1'b0;
        case (r_state)
            S_OFF: begin
                if (div_load_i)
                    w_nx_div_q = div_i;
                if (clk_en_i)
                    w_start = 1'b1;
            end
            S_RUN: begin
                if (r_div_q == '0) begin
                    if (w_stop)
                        w_nx_state = w_exit_st;
                end else if (w_stop && !(r_level && !w_last)) begin
                    // low phase, or high phase ending this cycle: stop at once
                    w_nx_state = w_exit_st;
                    w_nx_level = 1'b0;
                    w_nx_cnt   = '0;
                end else begin
                    if (w_last) begin
                        w_nx_level = !r_level;
                        w_nx_cnt   = '0;
                    end else begin
                        w_nx_cnt = r_cnt + DIV_W'(1);
                    end
                    if (w_stop)
                        w_nx_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    w_nx_state = w_exit_st;
                    w_nx_level = 1'b0;
                    w_nx_cnt   = '0;
                end else begin
                    w_nx_cnt = r_cnt + DIV_W'(1);
                end
            end
            S_PAUSE: begin
                if (!clk_en_i || r_reload_req || div_load_i)
                    w_nx_state = w_exit_st;
                else if (!w_pause)
                    w_start = 1'b1;
            end
            S_RELOAD: begin
                w_nx_div_q = div_load_i ? div_i : r_div_pend;
                w_start    = 1'b1;
            end
            default: w_nx_state = S_OFF;
        endcase
        if (w_start) begin
            w_nx_state = S_RUN;
            w_nx_cnt   = '0;
            w_nx_level = 1'b1;
        end
    end

    assign w_run_nx  = (w_nx_state == S_RUN) || (w_nx_state == S_STOP);
    assign w_div0_nx = (w_nx_state == S_RUN) && (w_nx_div_q == '0);
    assign w_nx_d1   = w_div0_nx || (w_run_nx && w_nx_level);
    assign w_nx_d2   = !w_div0_nx && w_run_nx && w_nx_level;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_OFF;
            r_cnt        <= '0;
            r_level      <= 1'b0;
            r_div_q      <= DIV_RESET;
            r_div_pend   <= DIV_RESET;
            r_reload_req <= 1'b0;
            r_d1         <= 1'b0;
            r_d2         <= 1'b0;
            r_ce         <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_stable     <= 1'b0;
            r_stab       <= '0;
        end else begin
            r_state      <= w_nx_state;
            r_cnt        <= w_nx_cnt;
            r_level      <= w_nx_level;
            r_div_q      <= w_nx_div_q;
            if (div_load_i)
                r_div_pend <= div_i;
            r_reload_req <= ((w_nx_state == S_STOP) || (w_nx_state == S_PAUSE)) &&
                            (r_reload_req || div_load_i);
            r_d1         <= w_nx_d1;
            r_d2         <= w_nx_d2;
            r_ce         <= 1'b1;
            r_rise       <= w_div0_nx || (w_run_nx && w_nx_d1 && !r_d1);
            r_fall       <= w_div0_nx || (w_run_nx && !w_nx_d1 && r_d1);
            // A pause holds the stable count; a stop or reload restarts it.
            if (!clk_en_i || div_load_i) begin
                r_stab   <= '0;
                r_stable <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_stab   <= w_stab_inc;
                r_stable <= (w_stab_inc >= STAB_MAX);
            end else if ((r_state == S_OFF) || (r_state == S_RELOAD)) begin
                r_stab   <= '0;
                r_stable <= 1'b0;
            end
        end
    end

    assign oddr_d1_o    = r_d1;
    assign oddr_d2_o    = r_d2;
    assign oddr_ce_o    = r_ce;
    assign sd_rise_o    = r_rise;
    assign sd_fall_o    = r_fall;
    assign clk_stable_o = r_stable;

endmodule

// File: doc/sd_clk_gen.md
Name: sd_clk_gen

Overview:
- Generates the SD card clock (SDCLK) for the SD host controller as per-cycle D1/D2 data pairs for the SAME_EDGE output DDR cell that drives the SDCLK pad.
- Sits directly upstream of that DDR output cell. Also issues rise/fall strobes so the CMD/DAT shifters stay aligned to SDCLK edges.
- Runs entirely in the base clock domain. Supports full-rate and divided SDCLK, glitch-free start/stop and divider change, and a stable indication for the register file.

Parameters:
- DIV_W, 10, width of divider value N; SDCLK = base/(2N) for N>=1, base for N=0.
- DIV_RESET, 10'd128, divider value loaded at reset (identification-mode rate).
- STABLE_CYC, 8, base cycles after a (re)start before clk_stable_o asserts; must be >=1.

Ports:
- clk_i  in  1  base clock; also the clock of the DDR output cell.
- rst_ni  in  1  asynchronous active-low reset.
- clk_en_i  in  1  level request: 1 = SDCLK running, 0 = SDCLK parked low.
- div_i  in  DIV_W  new divider value N.
- div_load_i  in  1  one-cycle pulse; capture div_i.
- oddr_d1_o  out  1  SDCLK level for the high phase of clk_i.
- oddr_d2_o  out  1  SDCLK level for the low phase of clk_i.
- oddr_ce_o  out  1  DDR cell clock enable.
- sd_rise_o  out  1  one-cycle strobe: SDCLK rises during this cycle.
- sd_fall_o  out  1  one-cycle strobe: SDCLK falls during this cycle.
- clk_stable_o  out  1  SDCLK running at the programmed rate.

Behaviour:
- All outputs are registered.
- Reset values:
  - d1, d2, sd_rise_o, sd_fall_o, clk_stable_o = 0.
  - oddr_ce_o = 0; goes to 1 on the first cycle after reset release and stays 1.
  - div_q = DIV_RESET, cnt = 0, state = OFF.
- States:
  - OFF: d1 = d2 = 0.
    - clk_en_i=1 -> RUN; cnt = 0; stable counter = 0.
  - RUN with div_q >= 1:
    - Phase level toggles when cnt == div_q-1, then cnt = 0; otherwise cnt++.
    - d1 = d2 = level.
    - SDCLK period is exactly 2*div_q base cycles, 50% duty.
    - The first high phase starts on the first RUN cycle.
  - RUN with div_q == 0: d1 = 1, d2 = 0 every cycle; sd_rise_o = sd_fall_o = 1 every cycle.
  - STOPPING: entered on clk_en_i=0 or div_load_i while level is high.
    - The high phase completes its full div_q cycles; no runt pulse.
    - Then: OFF if clk_en_i=0, otherwise RELOAD.
    - If level is already low, transition immediately.
  - RELOAD: one cycle, output low; div_q <= latched div; cnt = 0; next state RUN.
- Strobes:
  - sd_rise_o is high in exactly the cycle where d1 first presents 1 after being 0.
  - sd_fall_o is high in the cycle where d1 first presents 0 after being 1.
  - Never high in OFF or RELOAD.
- Divider loading:
  - div_load_i captures div_i into a pending register.
  - A second div_load_i before the reload completes overwrites the pending value; last value wins.
  - div_load_i in OFF updates div_q directly; no output change.
- clk_stable_o:
  - Drops to 0 in the cycle after div_load_i or clk_en_i falls.
  - Reasserts after STABLE_CYC consecutive RUN cycles at the new div_q.
- Simultaneous div_load_i and clk_en_i 0->1 in OFF: the new divider is used from the first RUN cycle.
- Asynchronous reset mid-phase forces all outputs low immediately. SDCLK may truncate; this is acceptable only at reset.

Optional Feature:
- SDCLK_PAUSE_EN.
  - Defined: adds input pause_i, 1 bit.
    - pause_i=1 in RUN enters STOPPING and parks SDCLK low after the current high phase; used for read-FIFO-full flow control.
    - Deasserting pause_i resumes RUN with cnt = 0.
    - clk_stable_o stays 1 during a pause.
    - Strobes stop while paused.
  - Undefined: no pause_i port and no pause logic.

Test Plan:
- Reset release with clk_en_i=0 -> d1=d2=0, strobes 0, oddr_ce_o=1 from cycle 1, clk_stable_o=0.
- clk_en_i=1, DIV_RESET=128 -> SDCLK period 256 cycles; rise/fall strobes 128 cycles apart; clk_stable_o=1 after 8 cycles.
- Running at N=4, div_load_i with div_i=0 mid-high-phase -> high phase lasts a full 4 cycles, 1 low RELOAD cycle, then d1=1/d2=0 every cycle with both strobes high; clk_stable_o low until 8 cycles later.
- Running at N=2, clk_en_i dropped one cycle into the high phase -> high phase lasts a full 2 cycles, then low permanently; no further strobes.
- Two div_load_i pulses (div_i=3, then 5) inside one high phase -> only N=5 is applied (period 10).
- Asynchronous reset asserted mid-high-phase -> d1, d2, strobes and clk_stable_o at 0 without a clock edge; div_q returns to 128.
